// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Load-use hazard detection and operand-forward selection for an in-order
//   pipeline. The block keeps its own shadow pipeline of in-flight destination
//   registers behind ID, so it does not need Rd/RegWr taps from the pipeline
//   registers. It sits beside the ID stage. IF, the ID/EXE pipeline register
//   and the control unit consume `stall`.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   issue_valid  a valid instruction is in ID this cycle
//   issue_rd     destination register of the ID instruction
//   issue_regwr  ID instruction writes the register file
//   issue_load   ID instruction is a memory load
//   rs1/rs1_used source A register and its read enable
//   rs2/rs2_used source B register and its read enable
//   kill         ID instruction is squashed (taken branch/jump)
//   stall        hold IF/ID and insert a bubble into stage 1
//   fwd_a/fwd_b  operand select: 0 = register file, k = stage k
//                (1 = EXE ... N_STAGES = WB)
//   inflight     number of valid, register-writing entries in flight
//   stall_count  saturating count of stall cycles
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned N_STAGES   = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned R0_ZERO    = 1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FW         = $clog2(N_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_regwr,
  input  logic                  issue_load,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic                  rs1_used,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs2_used,
  input  logic                  kill,
  output logic                  stall,
  output logic [FW-1:0]         fwd_a,
  output logic [FW-1:0]         fwd_b,
  output logic [FW-1:0]         inflight,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  ld;
  } entry_t;

  // Index 1 is the youngest entry (EXE). Index N_STAGES is the oldest (WB).
  entry_t ent [1:N_STAGES];

  logic accept;
  logic src_a_ok;
  logic src_b_ok;
  logic hazard_a;
  logic hazard_b;

  // A source takes part in matching only when ID holds a real instruction
  // that reads it. Register 0 is excluded when it is hard-wired to zero.
  assign src_a_ok = issue_valid && rs1_used && !((R0_ZERO != 0) && (rs1 == '0));
  assign src_b_ok = issue_valid && rs2_used && !((R0_ZERO != 0) && (rs2 == '0));

  // The stage-1 loop runs first, so the youngest match is taken.
  // A WB-stage match is also forwarded, which covers the case where the
  // register file is written and read in the same cycle.
  always_comb begin
    fwd_a    = '0;
    fwd_b    = '0;
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int unsigned k = 1; k <= N_STAGES; k++) begin
      if (src_a_ok && (fwd_a == '0) && ent[k].v && ent[k].wr && (ent[k].rd == rs1)) begin
        fwd_a    = FW'(k);
        hazard_a = ent[k].ld && (k < LOAD_STAGE);
      end
      if (src_b_ok && (fwd_b == '0) && ent[k].v && ent[k].wr && (ent[k].rd == rs2)) begin
        fwd_b    = FW'(k);
        hazard_b = ent[k].ld && (k < LOAD_STAGE);
      end
    end
  end

  // kill takes priority over a hazard: the squashed instruction needs no operands.
  assign stall  = (hazard_a || hazard_b) && !kill;
  assign accept = issue_valid && !kill && !stall;

  always_comb begin
    inflight = '0;
    for (int unsigned k = 1; k <= N_STAGES; k++) begin
      if (ent[k].v && ent[k].wr) begin
        inflight = inflight + FW'(1);
      end
    end
  end

  // The shadow pipeline always advances. A stall only puts a bubble into
  // stage 1, the same as the main pipeline does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 1; k <= N_STAGES; k++) begin
        ent[k] <= '0;
      end
      stall_count <= '0;
    end else begin
      for (int unsigned k = 2; k <= N_STAGES; k++) begin
        ent[k] <= ent[k-1];
      end
      if (accept) begin
        ent[1] <= '{v: 1'b1, rd: issue_rd, wr: issue_regwr, ld: issue_load};
      end else begin
        ent[1] <= '0;
      end
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int NS = 3;
  localparam int LS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_regwr, issue_load, rs1_used, rs2_used, kill;
  logic [2:0] issue_rd, rs1, rs2;

  logic        stall0, stall1, stall2;
  logic [1:0]  fa0, fb0, in0, fa1, fb1, in1, fa2, fb2, in2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_W(3), .N_STAGES(3), .LOAD_STAGE(2), .R0_ZERO(1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwr(issue_regwr), .issue_load(issue_load), .rs1(rs1), .rs1_used(rs1_used),
    .rs2(rs2), .rs2_used(rs2_used), .kill(kill), .stall(stall0), .fwd_a(fa0),
    .fwd_b(fb0), .inflight(in0), .stall_count(cnt0));

  hazard_scoreboard #(.REG_ADDR_W(3), .N_STAGES(3), .LOAD_STAGE(2), .R0_ZERO(0), .CNT_W(16)) u_r0 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwr(issue_regwr), .issue_load(issue_load), .rs1(rs1), .rs1_used(rs1_used),
    .rs2(rs2), .rs2_used(rs2_used), .kill(kill), .stall(stall1), .fwd_a(fa1),
    .fwd_b(fb1), .inflight(in1), .stall_count(cnt1));

  hazard_scoreboard #(.REG_ADDR_W(3), .N_STAGES(3), .LOAD_STAGE(2), .R0_ZERO(1), .CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwr(issue_regwr), .issue_load(issue_load), .rs1(rs1), .rs1_used(rs1_used),
    .rs2(rs2), .rs2_used(rs2_used), .kill(kill), .stall(stall2), .fwd_a(fa2),
    .fwd_b(fb2), .inflight(in2), .stall_count(cnt2));

  // Model: hist[v][a] is the instruction accepted a cycles ago.
  // v=0 treats register 0 as hard-wired zero. v=1 does not.
  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       wr;
    logic       ld;
  } rec_t;

  rec_t hist [0:1][1:NS];
  int   m_cnt [0:1];

  function automatic int exp_sel(input int v, input logic [2:0] s, input logic used,
                                 output logic ld);
    int sel = 0;
    ld = 1'b0;
    if (issue_valid && used && !(v == 0 && s == 3'd0)) begin
      for (int a = 1; a <= NS; a++) begin
        if (sel == 0 && hist[v][a].v && hist[v][a].wr && hist[v][a].rd == s) begin
          sel = a;
          ld  = hist[v][a].ld;
        end
      end
    end
    return sel;
  endfunction

  function automatic logic exp_stall(input int v);
    logic la, lb;
    int   sa, sb;
    sa = exp_sel(v, rs1, rs1_used, la);
    sb = exp_sel(v, rs2, rs2_used, lb);
    return ((la && sa < LS) || (lb && sb < LS)) && !kill;
  endfunction

  function automatic int exp_inflight(input int v);
    int n = 0;
    for (int a = 1; a <= NS; a++) if (hist[v][a].v && hist[v][a].wr) n++;
    return n;
  endfunction

  function automatic int sat(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < 2; v++) begin
        for (int a = 1; a <= NS; a++) hist[v][a] = '0;
        m_cnt[v] = 0;
      end
    end else begin
      for (int v = 0; v < 2; v++) begin
        logic st;
        st = exp_stall(v);
        for (int a = NS; a >= 2; a--) hist[v][a] = hist[v][a-1];
        if (issue_valid && !kill && !st)
          hist[v][1] = {1'b1, issue_rd, issue_regwr, issue_load};
        else
          hist[v][1] = '0;
        if (st) m_cnt[v]++;
      end
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Compare against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (started && !reset) begin
      logic d;
      chk("dut.stall", stall0, exp_stall(0));
      chk("dut.fwd_a", fa0, exp_sel(0, rs1, rs1_used, d));
      chk("dut.fwd_b", fb0, exp_sel(0, rs2, rs2_used, d));
      chk("dut.inflight", in0, exp_inflight(0));
      chk("dut.stall_count", cnt0, sat(m_cnt[0], 65535));
      chk("r0.stall", stall1, exp_stall(1));
      chk("r0.fwd_a", fa1, exp_sel(1, rs1, rs1_used, d));
      chk("r0.fwd_b", fb1, exp_sel(1, rs2, rs2_used, d));
      chk("r0.inflight", in1, exp_inflight(1));
      chk("r0.stall_count", cnt1, sat(m_cnt[1], 65535));
      chk("c2.stall", stall2, exp_stall(0));
      chk("c2.fwd_a", fa2, exp_sel(0, rs1, rs1_used, d));
      chk("c2.stall_count", cnt2, sat(m_cnt[0], 3));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] rd, input logic wr, input logic ld,
                       input logic [2:0] a, input logic ua, input logic [2:0] b,
                       input logic ub, input logic k);
    issue_valid = v; issue_rd = rd; issue_regwr = wr; issue_load = ld;
    rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub; kill = k;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst.stall", stall0, 0);
    chk("rst.fwd_a", fa0, 0);
    chk("rst.inflight", in0, 0);
    chk("rst.count", cnt0, 0);
    reset = 1'b0;
    started = 1'b1;

    // 1: reset clears state asynchronously, with no clock edge
    step(); drive(1, 5, 1, 1, 0, 0, 0, 0, 0);
    step(); drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
    #1;
    chk("t1.pre_stall", stall0, 1);
    chk("t1.pre_fwd_a", fa0, 1);
    chk("t1.pre_inflight", in0, 1);
    reset = 1'b1;
    #1;
    chk("t1.rst_stall", stall0, 0);
    chk("t1.rst_fwd_a", fa0, 0);
    chk("t1.rst_inflight", in0, 0);
    reset = 1'b0;
    #1;
    chk("t1.post_fwd_a", fa0, 0);
    chk("t1.post_stall", stall0, 0);

    // 2: ALU result forwarding by age
    step(); drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    step(); drive(1, 0, 0, 0, 3, 1, 0, 0, 0); #1;
    chk("t2.fwd_a_k1", fa0, 1); chk("t2.stall_k1", stall0, 0);
    step(); drive(1, 0, 0, 0, 0, 0, 3, 1, 0); #1;
    chk("t2.fwd_b_k2", fb0, 2); chk("t2.stall_k2", stall0, 0);
    step(); drive(1, 0, 0, 0, 3, 1, 0, 0, 0); #1;
    chk("t2.fwd_a_k3", fa0, 3); chk("t2.stall_k3", stall0, 0);
    step(); #1;
    chk("t2.fwd_a_gone", fa0, 0); chk("t2.stall_gone", stall0, 0);

    // 3: load-use stall lasts exactly one cycle
    step(); drive(1, 5, 1, 1, 0, 0, 0, 0, 0);
    step(); drive(1, 0, 0, 0, 5, 1, 0, 0, 0); #1;
    chk("t3.stall", stall0, 1); chk("t3.fwd_a_k1", fa0, 1); chk("t3.count0", cnt0, 0);
    step(); #1;
    chk("t3.stall_clear", stall0, 0); chk("t3.fwd_a_k2", fa0, 2);
    chk("t3.count1", cnt0, 1); chk("t3.inflight", in0, 1);

    // 4: youngest match wins
    step(); drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
    step();
    step(); drive(1, 0, 0, 0, 2, 1, 2, 1, 0); #1;
    chk("t4.fwd_a", fa0, 1); chk("t4.fwd_b", fb0, 1);
    chk("t4.inflight", in0, 2); chk("t4.stall", stall0, 0);

    // 5: register 0 never matches (unless R0_ZERO=0)
    step(); drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
    step(); drive(1, 0, 0, 0, 0, 1, 0, 1, 0); #1;
    chk("t5.stall", stall0, 0); chk("t5.fwd_a", fa0, 0); chk("t5.fwd_b", fb0, 0);
    chk("t5.r0_stall", stall1, 1); chk("t5.r0_fwd_a", fa1, 1); chk("t5.r0_fwd_b", fb1, 1);

    // 6: kill beats a hazard
    step(); drive(1, 4, 1, 1, 0, 0, 0, 0, 0);
    step(); drive(1, 0, 0, 0, 4, 1, 0, 0, 1); #1;
    chk("t6.kill_stall", stall0, 0); chk("t6.kill_fwd_a", fa0, 1);
    step(); drive(1, 0, 0, 0, 4, 1, 0, 0, 0); #1;
    chk("t6.after_stall", stall0, 0); chk("t6.after_fwd_a", fa0, 2);

    // 6b: five more load-use stalls, and the 2-bit counter saturates
    for (int i = 0; i < 5; i++) begin
      step(); drive(1, 6, 1, 1, 0, 0, 0, 0, 0);
      step(); drive(1, 0, 0, 0, 6, 1, 0, 0, 0); #1;
      chk("t6.loop_stall", stall0, 1);
      step(); #1;
      chk("t6.loop_clear", stall0, 0);
    end
    chk("t6.count16", cnt0, 6);
    chk("t6.count2_sat", cnt2, 3);

    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step(); step();
    #6;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed three-stage hazard/forwarding logic in the pipeline top.
- Owns a shadow pipeline of in-flight destination registers behind ID, instead of taking Rd and RegWr taps from each pipeline register.
- From that shadow pipeline it produces per-source forward selects, the load-use stall, and a saturating stall counter.
- Sits beside the ID stage; the control unit, IF and the pipeline registers consume its stall output.

Parameters:
REG_ADDR_W, 3, register-address width (2**REG_ADDR_W architectural registers)
N_STAGES, 3, number of tracked stages after ID (1=EXE, 2=MEM, 3=WB)
LOAD_STAGE, 2, first stage index at which load data can be forwarded
R0_ZERO, 1, when 1 register 0 never matches (no forward, no stall)
CNT_W, 16, stall-counter width
FW, $clog2(N_STAGES+1), derived forward-select width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  a valid instruction is in ID this cycle
issue_rd  in  REG_ADDR_W  destination register of the ID instruction
issue_regwr  in  1  ID instruction writes the register file
issue_load  in  1  ID instruction is a memory load
rs1  in  REG_ADDR_W  source A register
rs1_used  in  1  source A is read
rs2  in  REG_ADDR_W  source B register
rs2_used  in  1  source B is read
kill  in  1  ID instruction is squashed (taken branch/jump)
stall  out  1  hold IF/ID, insert bubble into stage 1
fwd_a  out  FW  source A select: 0=register file, k=stage k
fwd_b  out  FW  source B select, same encoding
inflight  out  FW  count of valid writing entries in stages 1..N_STAGES
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- State: entries 1..N_STAGES, each {v, rd, wr, ld}.
- Reset (asynchronous): all entries v=0 and stall_count=0, so stall=0, fwd_a=fwd_b=0, inflight=0.
- Each rising edge, unconditionally:
  - entry[k+1] <= entry[k] for k = 1..N_STAGES-1; entry[N_STAGES] retires.
  - entry[1] <= {1, issue_rd, issue_regwr, issue_load} when issue_valid && !kill && !stall.
  - Otherwise entry[1] <= bubble (v=0).
- The shadow pipeline never stalls: a stall only injects a bubble, matching the main pipeline's behaviour.
- Match rule for source s (rs1 or rs2):
  - Candidates are entries with v && wr && rd==s.
  - Excluded when R0_ZERO=1 and s==0.
  - Excluded when the matching *_used=0 or issue_valid=0.
- fwd_x is the lowest k (youngest) among candidates, or 0 if there is none.
- A stage-N_STAGES match forwards from WB; it covers same-cycle register-file write/read.
- Hazard: the selected candidate has ld=1 and k < LOAD_STAGE.
- stall = (hazard on A || hazard on B) && !kill. Combinational, zero latency from inputs.
- While stall=1, fwd outputs still show the current selection; the consumer ignores them.
- kill has priority over hazard: stall=0 and a bubble enters stage 1.
- Stalls resolve on their own: the load advances one stage per cycle.
  - For LOAD_STAGE=2, a load-use stalls exactly 1 cycle.
  - In general, a load-use stalls LOAD_STAGE-k cycles.
- stall_count increments on each clock with stall=1 and saturates at all-ones, with no wrap.
- inflight is the combinational popcount of v&&wr.
- Reset asserted mid-stream: state clears immediately and asynchronously. The first edge after deassert loads entry[1] from the inputs normally.

Test Plan:
1. Reset clears state.
   - Stimulus: issue load rd=5 and step 1 cycle; then pulse reset for half a cycle.
   - Required: stall=0, fwd_a=0, inflight=0 with no clock edge; next consumer rs1=5 gets fwd_a=0.
2. ALU result forwarding by age.
   - Stimulus: cycle 0 issue ALU rd=3 regwr=1; cycle 1 rs1=3; cycle 2 rs2=3; cycle 3 rs1=3; cycle 4 rs1=3.
   - Required: fwd_a=1, fwd_b=2, fwd_a=3, fwd_a=0 respectively; stall=0 throughout.
3. Load-use stall.
   - Stimulus: cycle 0 issue load rd=5; cycle 1 rs1=5 held.
   - Required: cycle 1 stall=1 with bubble into stage 1; cycle 2 stall=0, fwd_a=2; stall_count=1; inflight=1.
4. Youngest match wins.
   - Stimulus: issue rd=2 twice back-to-back, then rs1=rs2=2.
   - Required: fwd_a=fwd_b=1; inflight=2.
5. Register 0 never matches.
   - Stimulus: load rd=0, then rs1=0, rs2=0.
   - Required: stall=0, fwd_a=fwd_b=0. Repeat with R0_ZERO=0: stall=1.
6. Kill beats hazard, and counter saturates.
   - Stimulus: load rd=4, then rs1=4 with kill=1; next cycle rs1=4 with kill=0.
   - Required: kill cycle stall=0; following cycle stall=0, fwd_a=2.
   - With CNT_W=2: 5 forced stall cycles leave stall_count=3.
